// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC, drives the icache read port, latches fetched instructions
// into IF/ID, and stops fetching once a halt opcode is fetched on the
// correct path. Redirects that arrive while the PC is stalled are
// remembered and applied on the next PC advance.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   pc_en             PC advance enable from the hazard unit
//   pipe1_en          IF/ID latch enable from the hazard unit
//   flushed1          IF/ID flush from the hazard unit
//   ihit, imemload    icache hit and fetched instruction
//   pc_src            next-PC source (diaosi_types_pkg encoding)
//   branch_sel        branch taken
//   branch_addr, jump_addr, jr_addr   redirect targets
//   imemREN, imemaddr icache read enable and fetch address (= PC)
//   instr_o, npc_o, valid_o           IF/ID instruction, PC+4, valid
//   halted_o          fetch stopped by a halt
//   fetch_cnt         number of instructions latched into IF/ID

package diaosi_types_pkg;
    typedef enum logic [1:0] {
        SEQ_DIAOSI    = 2'd0,
        BRANCH_DIAOSI = 2'd1,
        JUMP_DIAOSI   = 2'd2,
        JR_DIAOSI     = 2'd3
    } pc_src_t;
endpackage

module fetch_unit
    import diaosi_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        pipe1_en,
    input  logic        flushed1,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic [1:0]  pc_src,
    input  logic        branch_sel,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] jr_addr,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_o,
    output logic [31:0] npc_o,
    output logic        valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_cnt
);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        pend, pend_next;
    logic [31:0] pend_addr, pend_addr_next;
    logic [31:0] cnt_q;

    pc_src_t     src;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        halt_hit;

    assign src      = pc_src_t'(pc_src);
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        redirect = 1'b0;
        target   = '0;
        case (src)
            BRANCH_DIAOSI: begin
                redirect = branch_sel;
                target   = branch_addr;
            end
            JUMP_DIAOSI: begin
                redirect = 1'b1;
                target   = jump_addr;
            end
            JR_DIAOSI: begin
                redirect = 1'b1;
                target   = jr_addr;
            end
            default: ;
        endcase
    end

    // A halt fetched alongside a redirect or flush is wrong-path and ignored.
    assign halt_hit = ihit && pc_en && !flushed1 && !redirect
                      && (imemload[31:26] == HALT_OP);

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        pend_next      = pend;
        pend_addr_next = pend_addr;
        case (state)
            FETCH: begin
                if (pc_en) begin
                    pend_next = 1'b0;
                    if (redirect)  pc_next = target;
                    else if (pend) pc_next = pend_addr;
                    else           pc_next = pc_plus4;
                    if (halt_hit)  state_next = HALTED;
                end else if (redirect) begin
                    // Newest redirect during a stall overwrites any older one.
                    pend_next      = 1'b1;
                    pend_addr_next = target;
                end
            end
            HALTED: ;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            pend      <= pend_next;
            pend_addr <= pend_addr_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_o <= '0;
            npc_o   <= '0;
            valid_o <= 1'b0;
            cnt_q   <= '0;
        end else if (flushed1) begin
            instr_o <= '0;
            npc_o   <= '0;
            valid_o <= 1'b0;
        end else if (pipe1_en && ihit) begin
            instr_o <= imemload;
            npc_o   <= pc_plus4;
            valid_o <= 1'b1;
            cnt_q   <= cnt_q + 32'd1;
        end
    end

    assign imemREN   = (state == FETCH);
    assign imemaddr  = pc;
    assign halted_o  = (state == HALTED);
    assign fetch_cnt = cnt_q;

endmodule
